// File: rtl/udp_tx_scheduler_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM encoding, header length, index widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package udp_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // IPv4 header (20) + UDP header (8) bytes added in front of the payload.
  localparam logic [15:0] IP_UDP_HDR_LEN = 16'd28;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_rr_arbiter.sv
// Round-robin pick: first requesting channel at or after rr_ptr, wrapping past NUM_CH-1.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (per-channel request), rr_ptr (search start), gnt (one-hot winner), idx (winner index).
module udp_rr_arbiter
  import udp_tx_scheduler_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IDX_W = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  localparam logic [IDX_W:0] NCH = (IDX_W + 1)'(NUM_CH);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= NCH) cand = cand - NCH;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP transmitter among NUM_CH sources, one packet per round-robin grant.
// Latency: request seen in IDLE -> grant +1 clk -> tx_start +2 clk; eop -> next start GAP_CYCLES+3.
// Backpressure: channels hold ch_req until ch_done; requests are ignored outside IDLE.
// Ports: ch_* per-channel request/params/payload in, grant/read/done out; tx_* transmitter
//        handshake; udp_*/ip_* latched header fields; busy high outside IDLE.
module udp_tx_scheduler
  import udp_tx_scheduler_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          GAP_CYCLES = 12,
  parameter logic [15:0] IP_ID_INIT = 16'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH*16-1:0] ch_src_port,
  input  logic [NUM_CH*16-1:0] ch_dst_port,
  input  logic [NUM_CH*16-1:0] ch_len,
  input  logic [NUM_CH*16-1:0] ch_chksum,
  input  logic [NUM_CH*32-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_grant,
  output logic [NUM_CH-1:0]    ch_data_rd,
  output logic [NUM_CH-1:0]    ch_done,
  output logic                 tx_start,
  input  logic                 tx_eop,
  input  logic                 tx_data_in_rd,
  output logic [31:0]          tx_data_in,
  output logic [15:0]          udp_src_port,
  output logic [15:0]          udp_dst_port,
  output logic [15:0]          udp_data_length,
  output logic [15:0]          udp_data_chksum,
  output logic [15:0]          ip_total_len,
  output logic [15:0]          ip_id,
  output logic                 busy
);

  localparam int IDX_W = idx_w(NUM_CH);
  localparam int CNT_W = idx_w(GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  state_t            state, nxt;
  logic [IDX_W-1:0]  sel, rr_ptr, arb_idx;
  logic [NUM_CH-1:0] arb_gnt, sel_oh;
  logic [CNT_W-1:0]  gap_cnt;
  logic              arb_vld;

  udp_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req    (ch_req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  assign arb_vld    = |arb_gnt;
  assign sel_oh     = {{(NUM_CH-1){1'b0}}, 1'b1} << sel;
  // The payload mux follows sel in every state; only the read strobe is gated by BUSY.
  assign tx_data_in = ch_data[32*sel +: 32];

  always_comb begin
    nxt        = state;
    ch_grant   = '0;
    ch_data_rd = '0;
    ch_done    = '0;
    tx_start   = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (arb_vld) nxt = ST_LOAD;
      ST_LOAD: begin
        ch_grant = sel_oh;
        nxt      = ST_START;
      end
      ST_START: begin
        // Any eop seen here is spurious: the transmitter cannot finish in its start cycle.
        tx_start = 1'b1;
        nxt      = ST_BUSY;
      end
      ST_BUSY: begin
        ch_data_rd = tx_data_in_rd ? sel_oh : '0;
        if (tx_eop) begin
          ch_done = sel_oh;
          nxt     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP:   if (gap_cnt == '0) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      sel             <= '0;
      rr_ptr          <= '0;
      gap_cnt         <= '0;
      ip_id           <= IP_ID_INIT;
      udp_src_port    <= '0;
      udp_dst_port    <= '0;
      udp_data_length <= '0;
      udp_data_chksum <= '0;
      ip_total_len    <= '0;
    end else begin
      state <= nxt;
      case (state)
        ST_IDLE: if (arb_vld) sel <= arb_idx;
        ST_LOAD: begin
          udp_src_port    <= ch_src_port[16*sel +: 16];
          udp_dst_port    <= ch_dst_port[16*sel +: 16];
          udp_data_length <= ch_len[16*sel +: 16];
          udp_data_chksum <= ch_chksum[16*sel +: 16];
          ip_total_len    <= ch_len[16*sel +: 16] + IP_UDP_HDR_LEN;
        end
        ST_BUSY: if (tx_eop) begin
          rr_ptr  <= (sel == LAST_CH) ? '0 : sel + 1'b1;
          ip_id   <= ip_id + 16'd1;
          gap_cnt <= GAP_LOAD;
        end
        ST_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler with a transaction-timeline reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_udp_tx_scheduler;

  localparam int          NUM_CH = 2;
  localparam int          GAP    = 12;
  localparam logic [15:0] ID0    = 16'hFFFE;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH*16-1:0] ch_src_port, ch_dst_port, ch_len, ch_chksum;
  logic [NUM_CH*32-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_grant, ch_data_rd, ch_done;
  logic                 tx_start, tx_eop, tx_data_in_rd, busy;
  logic [31:0]          tx_data_in;
  logic [15:0]          udp_src_port, udp_dst_port, udp_data_length, udp_data_chksum;
  logic [15:0]          ip_total_len, ip_id;

  udp_tx_scheduler #(.NUM_CH(NUM_CH), .GAP_CYCLES(GAP), .IP_ID_INIT(ID0)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req),
    .ch_src_port(ch_src_port), .ch_dst_port(ch_dst_port), .ch_len(ch_len),
    .ch_chksum(ch_chksum), .ch_data(ch_data),
    .ch_grant(ch_grant), .ch_data_rd(ch_data_rd), .ch_done(ch_done),
    .tx_start(tx_start), .tx_eop(tx_eop), .tx_data_in_rd(tx_data_in_rd),
    .tx_data_in(tx_data_in),
    .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port),
    .udp_data_length(udp_data_length), .udp_data_chksum(udp_data_chksum),
    .ip_total_len(ip_total_len), .ip_id(ip_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: tracks the packet currently owning the transmitter as a timeline
  // (grant cycle, start cycle, cycle from which arbitration is allowed again).
  bit          m_act;
  int          m_ch, m_rr, m_gcyc, m_scyc, m_okcyc;
  logic [15:0] m_id, m_src, m_dst, m_len, m_chk, m_tot;

  always @(negedge clk) begin
    logic [NUM_CH-1:0] oh, e_grant, e_done, e_rd;
    bit                in_busy, e_busy, e_start;
    if (!rst_n) begin
      m_act = 1'b0; m_ch = 0; m_rr = 0; m_gcyc = 0; m_scyc = 0; m_okcyc = 0;
      m_id = ID0; m_src = '0; m_dst = '0; m_len = '0; m_chk = '0; m_tot = '0;
    end
    oh      = NUM_CH'(1) << m_ch;
    in_busy = m_act && (cyc > m_scyc);
    e_grant = (m_act && cyc == m_gcyc) ? oh : '0;
    e_start = m_act && (cyc == m_scyc);
    e_done  = (in_busy && tx_eop) ? oh : '0;
    e_rd    = (in_busy && tx_data_in_rd) ? oh : '0;
    e_busy  = m_act || (cyc < m_okcyc);
    chk("grant", ch_grant, e_grant);
    chk("start", tx_start, e_start);
    chk("done", ch_done, e_done);
    chk("data_rd", ch_data_rd, e_rd);
    chk("busy", busy, e_busy);
    chk("tx_data_in", tx_data_in, ch_data[32*m_ch +: 32]);
    chk("ip_id", ip_id, m_id);
    chk("ip_total_len", ip_total_len, m_tot);
    chk("src_port", udp_src_port, m_src);
    chk("dst_port", udp_dst_port, m_dst);
    chk("data_len", udp_data_length, m_len);
    chk("chksum", udp_data_chksum, m_chk);
    if (rst_n) begin
      if (!m_act && cyc >= m_okcyc && |ch_req) begin
        for (int k = NUM_CH - 1; k >= 0; k--)
          if (ch_req[(m_rr + k) % NUM_CH]) m_ch = (m_rr + k) % NUM_CH;
        m_act  = 1'b1;
        m_gcyc = cyc + 1;
        m_scyc = cyc + 2;
      end else if (m_act && cyc == m_gcyc) begin
        m_src = ch_src_port[16*m_ch +: 16];
        m_dst = ch_dst_port[16*m_ch +: 16];
        m_len = ch_len[16*m_ch +: 16];
        m_chk = ch_chksum[16*m_ch +: 16];
        m_tot = m_len + 16'd28;
      end else if (in_busy && tx_eop) begin
        m_act   = 1'b0;
        m_rr    = (m_ch + 1) % NUM_CH;
        m_id    = m_id + 16'd1;
        m_okcyc = cyc + 1 + GAP;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("start_seen", {31'b0, tx_start}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r, t_eop;
    ch_req        = '0;
    tx_eop        = 1'b0;
    tx_data_in_rd = 1'b0;
    ch_src_port   = {16'h0A0B, 16'h1000};
    ch_dst_port   = {16'h0C0D, 16'h2000};
    ch_len        = {16'hFFF0, 16'd5};
    ch_chksum     = {16'hBEEF, 16'h1234};
    ch_data       = {32'hCAFEF00D, 32'h11111111};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_ip_id", ip_id, 16'hFFFE);
    chk("rst_busy", busy, 0);
    chk("rst_total_len", ip_total_len, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single request on ch0: grant next cycle, start the one after.
    ch_req = 2'b01;
    r = cyc;
    tick();
    chk("t1_grant", ch_grant, 2'b01);
    tick();
    chk("t1_start", tx_start, 1);
    chk("t1_total_len", ip_total_len, 16'd33);
    chk("t1_ip_id", ip_id, 16'hFFFE);
    chk("t1_len", udp_data_length, 16'd5);
    repeat (20) tick();
    tx_eop = 1'b1;
    #1;
    chk("t1_done", ch_done, 2'b01);
    t_eop = cyc;
    tick();
    tx_eop = 1'b0;
    ch_req = 2'b10;

    // Gap: stray eop ignored, next start exactly GAP+3 after eop.
    tick();
    tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    wait_start(40);
    chk("t3_gap_start", cyc - t_eop, 15);
    chk("t5_total_len", ip_total_len, 16'h000C);
    chk("t5_ip_id", ip_id, 16'hFFFF);
    tx_eop = 1'b1;
    #1;
    chk("start_eop_ignored", ch_done, 0);
    tick();
    tx_eop = 1'b0;

    // Payload read routing on ch1.
    for (int i = 0; i < 6; i++) begin
      tx_data_in_rd = i[0];
      #1;
      chk("t4_rd", ch_data_rd, {i[0], 1'b0});
      chk("t4_data", tx_data_in, 32'hCAFEF00D);
      tick();
    end
    tx_data_in_rd = 1'b0;
    tx_eop = 1'b1;
    #1;
    chk("t4_done", ch_done, 2'b10);
    tick();
    tx_eop = 1'b0;

    // Both requesting: strict alternation, ip_id wraps through zero.
    ch_req = 2'b11;
    for (int p = 0; p < 4; p++) begin
      wait_start(40);
      chk("t2_ip_id", ip_id, p);
      chk("t2_owner", udp_src_port, (p % 2 == 0) ? 16'h1000 : 16'h0A0B);
      repeat (20) tick();
      tx_eop = 1'b1;
      #1;
      chk("t2_done", ch_done, (p % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      tx_eop = 1'b0;
    end
    ch_req = 2'b00;

    // Reset in the middle of a packet after the requester has already dropped.
    repeat (14) tick();
    ch_req = 2'b01;
    wait_start(40);
    tick(); tick();
    ch_req = 2'b00;
    tick(); tick();
    chk("t6_still_busy", busy, 1);
    tx_eop = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", ch_done, 0);
    chk("t6_rst_start", tx_start, 0);
    chk("t6_rst_ip_id", ip_id, 16'hFFFE);
    chk("t6_rst_src", udp_src_port, 0);
    chk("t6_rst_total_len", ip_total_len, 0);
    tick();
    tx_eop = 1'b0;
    tick();
    rst_n  = 1'b1;
    ch_req = 2'b11;
    wait_start(10);
    chk("t6_ip_id", ip_id, 16'hFFFE);
    chk("t6_src", udp_src_port, 16'h1000);
    repeat (5) tick();
    tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    ch_req = 2'b00;
    repeat (16) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
